// File: rtl/ysyx_24100005_isram.sv
// rtl/ysyx_24100005_isram.sv - fixed-latency instruction memory responder for the fetch interface
// Accepts one PC per handshake, answers LATENCY cycles later; bad PCs return ebreak with rsp_err.
module ysyx_24100005_isram #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          AW      = 10,
  parameter int          LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          busy
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_RESP = 2'd2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  // 33-bit limit so a window ending at the top of the address space does not wrap
  localparam logic [32:0] LIMIT  = {1'b0, BASE} + 33'(4 * DEPTH);

  logic [1:0]    state;
  logic [3:0]    count;
  logic [31:0]   addr_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic          enter_resp;
  logic [31:0]   fetch_addr;
  logic          fetch_err;
  logic [AW-1:0] fetch_idx;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr < BASE) ||
                   ({1'b0, req_addr} >= LIMIT);

  // With LATENCY==1 the response is built on the accept edge, straight from the request port
  assign fetch_addr = (state == S_IDLE) ? req_addr : addr_q;
  assign fetch_err  = (state == S_IDLE) ? req_err  : err_q;
  assign fetch_idx  = AW'((fetch_addr - BASE) >> 2);

  assign enter_resp = ((state == S_IDLE) && accept && (LATENCY == 1)) ||
                      ((state == S_WAIT) && (count == 4'd1));

  // Loader writes use non-blocking update, so a same-edge fetch still sees the old word
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= 4'd0;
      addr_q   <= 32'h0;
      err_q    <= 1'b0;
      rsp_inst <= 32'h0;
      rsp_err  <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_err  <= fetch_err;
        rsp_inst <= fetch_err ? EBREAK : mem[fetch_idx];
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            err_q  <= req_err;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              count <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state   <= S_IDLE;
            rsp_err <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_isram.sv
// tb/tb_ysyx_24100005_isram.sv - directed bench for the instruction memory responder
// Main instance uses LATENCY=2; two more instances cover LATENCY=1 and LATENCY=15.
module tb_ysyx_24100005_isram;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] M0     = 32'h0010_0093;
  localparam logic [31:0] M1     = 32'h0020_0113;
  localparam logic [31:0] M2     = 32'h0030_0193;
  localparam logic [31:0] M3     = 32'h0040_0213;
  localparam logic [31:0] MTOP   = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        busy;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [31:0] ld_data = 32'h0;

  logic        xrv [2];
  logic        xrr [2];
  logic [31:0] xra [2];
  logic        xsv [2];
  logic        xsr [2];
  logic [31:0] xsi [2];
  logic        xse [2];
  logic        xbusy [2];

  logic [31:0] exp_mem [3];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_24100005_isram #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  ysyx_24100005_isram #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(xrv[0]), .req_ready(xrr[0]), .req_addr(xra[0]),
    .rsp_valid(xsv[0]), .rsp_ready(xsr[0]), .rsp_inst(xsi[0]), .rsp_err(xse[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(xbusy[0])
  );

  ysyx_24100005_isram #(.LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst(rst), .req_valid(xrv[1]), .req_ready(xrr[1]), .req_addr(xra[1]),
    .rsp_valid(xsv[1]), .rsp_ready(xsr[1]), .rsp_inst(xsi[1]), .rsp_err(xse[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(xbusy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] data);
    ld_en = 1'b1;
    ld_addr = idx;
    ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  // Issue one request on the main instance and wait for rsp_valid; lat counts cycles from accept cycle
  task automatic fetch(input logic [31:0] addr, output int lat);
    req_addr = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFF0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("fetch_rsp_valid", rsp_valid, 1);
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic b2b(input int k, input int lat_exp);
    int acc_cyc [3];
    int na;
    int nr;
    logic acc;
    na = 0;
    nr = 0;
    acc_cyc = '{0, 0, 0};
    xra[k] = BASE;
    xrv[k] = 1'b1;
    xsr[k] = 1'b1;
    for (int c = 0; c < 200 && nr < 3; c++) begin
      acc = xrv[k] && xrr[k];
      tick();
      if (acc) begin
        acc_cyc[na] = c;
        na++;
        if (na == 3) xrv[k] = 1'b0;
        else xra[k] = BASE + 32'(4 * na);
      end
      if (xsv[k]) begin
        check($sformatf("b2b_l%0d_inst%0d", lat_exp, nr), xsi[k], exp_mem[nr]);
        check($sformatf("b2b_l%0d_lat%0d", lat_exp, nr), 32'(c + 1 - acc_cyc[nr]), 32'(lat_exp));
        nr++;
      end
    end
    xsr[k] = 1'b0;
    xrv[k] = 1'b0;
    check($sformatf("b2b_l%0d_count", lat_exp), 32'(nr), 32'd3);
    check($sformatf("b2b_l%0d_gap0", lat_exp), 32'(acc_cyc[1] - acc_cyc[0]), 32'(lat_exp + 1));
    check($sformatf("b2b_l%0d_gap1", lat_exp), 32'(acc_cyc[2] - acc_cyc[1]), 32'(lat_exp + 1));
  endtask

  initial begin
    int lat;
    int seen;
    for (int k = 0; k < 2; k++) begin
      xrv[k] = 1'b0;
      xra[k] = 32'h0;
      xsr[k] = 1'b0;
    end
    exp_mem[0] = M0;
    exp_mem[1] = M1;
    exp_mem[2] = M2;

    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_inst", rsp_inst, 32'h0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);

    load(10'd0, M0);
    load(10'd1, M1);
    load(10'd2, M2);
    load(10'd3, M3);
    load(10'd1023, MTOP);

    // Basic fetch with cycle-by-cycle view
    req_addr = BASE;
    req_valid = 1'b1;
    check("t1_c0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("t1_c1_ready", req_ready, 0);
    check("t1_c1_valid", rsp_valid, 0);
    check("t1_c1_busy", busy, 1);
    tick();
    check("t1_c2_ready", req_ready, 0);
    check("t1_c2_valid", rsp_valid, 1);
    check("t1_c2_inst", rsp_inst, M0);
    check("t1_c2_err", rsp_err, 0);
    complete();
    check("t1_done_valid", rsp_valid, 0);
    check("t1_done_inst_hold", rsp_inst, M0);

    // Backpressure: response holds and a new request is ignored
    fetch(BASE + 32'h4, lat);
    check("t2_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", rsp_valid, 1);
      check("t2_inst", rsp_inst, M1);
      check("t2_err", rsp_err, 0);
      check("t2_ready", req_ready, 0);
      req_valid = (i == 2);
      req_addr = BASE + 32'h4;
      tick();
    end
    req_valid = 1'b0;
    complete();
    check("t2_busy_after", busy, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("t2_no_ghost_rsp", 32'(seen), 32'd0);

    // Address errors and the last legal word
    fetch(32'h8000_0002, lat);
    check("t3_misalign_err", rsp_err, 1);
    check("t3_misalign_inst", rsp_inst, EBREAK);
    complete();
    check("t3_err_cleared", rsp_err, 0);
    fetch(32'h8000_1000, lat);
    check("t3_above_err", rsp_err, 1);
    check("t3_above_inst", rsp_inst, EBREAK);
    complete();
    fetch(32'h7FFF_FFFC, lat);
    check("t3_below_err", rsp_err, 1);
    complete();
    fetch(32'h8000_0FFC, lat);
    check("t3_top_err", rsp_err, 0);
    check("t3_top_inst", rsp_inst, MTOP);
    complete();

    // Loader write on the RESP-entry edge is not visible to that fetch
    req_addr = BASE + 32'hC;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ld_en = 1'b1;
    ld_addr = 10'd3;
    ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    check("t5_race_valid", rsp_valid, 1);
    check("t5_race_old", rsp_inst, M3);
    complete();
    fetch(BASE + 32'hC, lat);
    check("t5_new", rsp_inst, 32'hDEAD_BEEF);
    complete();

    b2b(0, 1);
    b2b(1, 15);

    // Asynchronous reset in WAIT
    req_addr = BASE;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t6_busy_wait", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", rsp_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_inst", rsp_inst, 32'h0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("t6_no_stale", 32'(seen), 32'd0);
    fetch(BASE + 32'h4, lat);
    check("t6_after_lat", 32'(lat), 32'd2);
    check("t6_after_inst", rsp_inst, M1);
    complete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
